// File: rtl/irq_arbiter.sv
// irq_arbiter
//   Machine-level interrupt arbiter for three level-sensitive sources
//   (external, software, timer). Registers the pending bits, selects the
//   highest-priority enabled source (ext > sw > timer), and presents one
//   committed request to the core. The request is held until the core
//   acknowledges it. The arbiter then stays in the handler state until mret.
//
//   Parameter
//     VECTORED     1: target = aligned base + 4*code, 0: target = aligned base
//   Configuration macro
//     IRQ_EXT_SYNC_EN  when defined, ext_irq passes through a 2-flop
//                      synchronizer ahead of mip[2]
//   Ports
//     clk          clock, rising edge
//     rst_n        synchronous active-low reset
//     timer_irq    level timer interrupt
//     sw_irq       level software interrupt
//     ext_irq      level external interrupt (may be asynchronous)
//     mstatus_mie  global interrupt enable
//     mie[2:0]     per-source enable {ext, sw, timer}
//     mtvec_base   trap base address, bits [1:0] ignored
//     irq_ack      core accepts the presented request
//     mret         core returns from the handler
//     irq_req      interrupt request to the core
//     irq_cause    mcause value of the presented request
//     irq_target   handler PC of the presented request
//     mip[2:0]     registered pending bits {ext, sw, timer}
//     in_handler   high while a handler is active
//
//   state  | meaning
//   IDLE   | no request outstanding, evaluating mip & mie
//   REQ    | request committed and presented, waiting for irq_ack
//   ACTIVE | handler running, waiting for mret
module irq_arbiter #(
    parameter int VECTORED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_irq,
    input  logic        sw_irq,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic [2:0]  mie,
    input  logic [31:0] mtvec_base,
    input  logic        irq_ack,
    input  logic        mret,
    output logic        irq_req,
    output logic [31:0] irq_cause,
    output logic [31:0] irq_target,
    output logic [2:0]  mip,
    output logic        in_handler
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam logic [3:0] CODE_EXT   = 4'd11;
    localparam logic [3:0] CODE_SW    = 4'd3;
    localparam logic [3:0] CODE_TIMER = 4'd7;

    logic [1:0]  state_q, state_d;
    logic [2:0]  mip_q;
    logic [31:0] cause_q, cause_d;
    logic [31:0] target_q, target_d;
    logic        ext_smp;

`ifdef IRQ_EXT_SYNC_EN
    logic ext_s1_q, ext_s2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_s1_q <= 1'b0;
            ext_s2_q <= 1'b0;
        end else begin
            ext_s1_q <= ext_irq;
            ext_s2_q <= ext_s1_q;
        end
    end

    assign ext_smp = ext_s2_q;
`else
    assign ext_smp = ext_irq;
`endif

    logic [2:0]  pending;
    logic [3:0]  code;
    logic [31:0] base_al;
    logic [31:0] target_new;
    logic        unused_base_lsb;

    assign pending         = mip_q & mie;
    assign base_al         = {mtvec_base[31:2], 2'b00};
    assign unused_base_lsb = ^mtvec_base[1:0];

    always_comb begin
        code = CODE_TIMER;
        if (pending[2]) begin
            code = CODE_EXT;
        end else if (pending[1]) begin
            code = CODE_SW;
        end
    end

    // 4*code is at most 44, so the add simply wraps at 32 bits.
    assign target_new = (VECTORED != 0) ? (base_al + {26'd0, code, 2'b00}) : base_al;

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (mstatus_mie && (pending != 3'b000)) begin
                    state_d  = ST_REQ;
                    cause_d  = {1'b1, 27'd0, code};
                    target_d = target_new;
                end
            end
            // Once committed, the request ignores source and enable changes.
            ST_REQ: begin
                if (irq_ack) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (mret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mip_q    <= 3'b000;
            cause_q  <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mip_q    <= {ext_smp, sw_irq, timer_irq};
            cause_q  <= cause_d;
            target_q <= target_d;
        end
    end

    assign irq_req    = (state_q == ST_REQ);
    assign in_handler = (state_q == ST_ACTIVE);
    assign irq_cause  = cause_q;
    assign irq_target = target_q;
    assign mip        = mip_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: two instances (vectored and direct) share stimulus.
// Directed tasks check fixed expected values; a randomized phase checks
// both instances against a cycle-level reference model.
module tb_irq_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        timer_irq, sw_irq, ext_irq, mstatus_mie;
    logic [2:0]  mie;
    logic [31:0] mtvec_base;
    logic        irq_ack, mret;

    logic        req_v, req_d, inh_v, inh_d;
    logic [31:0] cause_v, cause_d, tgt_v, tgt_d;
    logic [2:0]  mip_v, mip_d;

    int errors = 0;
    int checks = 0;

    irq_arbiter #(.VECTORED(1)) dut_v (
        .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie),
        .mtvec_base(mtvec_base), .irq_ack(irq_ack), .mret(mret),
        .irq_req(req_v), .irq_cause(cause_v), .irq_target(tgt_v),
        .mip(mip_v), .in_handler(inh_v)
    );

    irq_arbiter #(.VECTORED(0)) dut_d (
        .clk(clk), .rst_n(rst_n), .timer_irq(timer_irq), .sw_irq(sw_irq),
        .ext_irq(ext_irq), .mstatus_mie(mstatus_mie), .mie(mie),
        .mtvec_base(mtvec_base), .irq_ack(irq_ack), .mret(mret),
        .irq_req(req_d), .irq_cause(cause_d), .irq_target(tgt_d),
        .mip(mip_d), .in_handler(inh_d)
    );

    always #5 clk = ~clk;

`ifdef IRQ_EXT_SYNC_EN
    localparam int EXT_LAT = 4;
`else
    localparam int EXT_LAT = 2;
`endif

    // Reference model: phase 0 = nothing outstanding, 1 = presented,
    // 2 = handler running. Sources reach the pending view after a delay line.
    int          m_phase = 0;
    logic [2:0]  m_mip = 3'b000;
    logic [2:0]  ext_line = 3'b000;
    logic [31:0] m_cause = 32'd0, m_tv = 32'd0, m_td = 32'd0;

    task automatic model_update();
        logic [2:0] en;
        int         c;
        if (!rst_n) begin
            m_phase = 0; m_mip = 0; ext_line = 0;
            m_cause = 0; m_tv = 0; m_td = 0;
        end else begin
            en = m_mip & mie;
            if (m_phase == 0 && mstatus_mie && en != 0) begin
                if (en[2]) c = 11;
                else if (en[1]) c = 3;
                else c = 7;
                m_phase = 1;
                m_cause = 32'h8000_0000 + 32'(c);
                m_td    = mtvec_base & 32'hFFFF_FFFC;
                m_tv    = m_td + 32'(4 * c);
            end else if (m_phase == 1 && irq_ack) begin
                m_phase = 2;
            end else if (m_phase == 2 && mret) begin
                m_phase = 0;
            end
`ifdef IRQ_EXT_SYNC_EN
            m_mip    = {ext_line[1], sw_irq, timer_irq};
            ext_line = {ext_line[1:0], ext_irq};
`else
            m_mip    = {ext_irq, sw_irq, timer_irq};
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        timer_irq = 0; sw_irq = 0; ext_irq = 0; mstatus_mie = 0;
        mie = 3'b000; mtvec_base = 32'h100; irq_ack = 0; mret = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; timer_irq = 1; sw_irq = 1; ext_irq = 1;
        mie = 3'b111; mstatus_mie = 1;
        tick(); tick();
        checks++;
        if ({req_v, inh_v, mip_v, cause_v, tgt_v} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs_v: got req=%b inh=%b mip=%b cause=%h tgt=%h, want all 0",
                     req_v, inh_v, mip_v, cause_v, tgt_v);
        end
        checks++;
        if ({req_d, inh_d, mip_d, cause_d, tgt_d} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs_d: got req=%b inh=%b mip=%b cause=%h tgt=%h, want all 0",
                     req_d, inh_d, mip_d, cause_d, tgt_d);
        end
        rst_n = 1;
        tick();
        checks++;
        if (req_v !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_req: got %b want 0", req_v);
        end
        rst_n = 0; idle_inputs();
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic test_timer_vectored();
        mstatus_mie = 1; mie = 3'b001; mtvec_base = 32'h100;
        tick();
        timer_irq = 1;
        tick();
        checks++;
        if (req_v !== 1'b0) begin
            errors++; $display("FAIL timer_lat1_req: got %b want 0", req_v);
        end
        tick();
        checks++;
        if ({req_v, cause_v, tgt_v, tgt_d} !== {1'b1, 32'h8000_0007, 32'h11C, 32'h100}) begin
            errors++;
            $display("FAIL timer_req: got req=%b cause=%h tv=%h td=%h want 1 80000007 11c 100",
                     req_v, cause_v, tgt_v, tgt_d);
        end
        irq_ack = 1; tick(); irq_ack = 0;
        checks++;
        if ({req_v, inh_v} !== 2'b01) begin
            errors++; $display("FAIL timer_ack: got req=%b inh=%b want 0 1", req_v, inh_v);
        end
        timer_irq = 0;
        tick(); tick();
        checks++;
        if (inh_v !== 1'b1) begin
            errors++; $display("FAIL timer_hold_active: got inh=%b want 1", inh_v);
        end
        mret = 1; tick(); mret = 0;
        checks++;
        if ({req_v, inh_v} !== 2'b00) begin
            errors++; $display("FAIL timer_mret: got req=%b inh=%b want 0 0", req_v, inh_v);
        end
        mret = 1; irq_ack = 1; tick(); mret = 0; irq_ack = 0;
        checks++;
        if ({req_v, inh_v} !== 2'b00) begin
            errors++; $display("FAIL idle_ignore: got req=%b inh=%b want 0 0", req_v, inh_v);
        end
    endtask

    task automatic test_priority();
        int bad;
        timer_irq = 1; sw_irq = 1; ext_irq = 1;
        mstatus_mie = 1; mie = 3'b000; mtvec_base = 32'h100;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_v !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mie_zero_blocks: got %0d cycles with req, want 0", bad);
        end
        mie = 3'b111; mstatus_mie = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (req_v !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || mip_v !== 3'b111) begin
            errors++;
            $display("FAIL gmie_zero_blocks: got %0d req cycles mip=%b, want 0 and 111", bad, mip_v);
        end
        mstatus_mie = 1;
        tick();
        checks++;
        if ({req_v, cause_v, tgt_v} !== {1'b1, 32'h8000_000B, 32'h12C}) begin
            errors++;
            $display("FAIL prio_ext: got req=%b cause=%h tgt=%h want 1 8000000b 12c",
                     req_v, cause_v, tgt_v);
        end
        irq_ack = 1; ext_irq = 0; tick(); irq_ack = 0;
        tick(); tick(); tick();
        mret = 1; tick(); mret = 0;
        checks++;
        if ({req_v, inh_v} !== 2'b00) begin
            errors++; $display("FAIL prio_mret: got req=%b inh=%b want 0 0", req_v, inh_v);
        end
        tick();
        checks++;
        if ({req_v, cause_v, tgt_v} !== {1'b1, 32'h8000_0003, 32'h10C}) begin
            errors++;
            $display("FAIL prio_sw_next: got req=%b cause=%h tgt=%h want 1 80000003 10c",
                     req_v, cause_v, tgt_v);
        end
        irq_ack = 1; tick(); irq_ack = 0;
        timer_irq = 0; sw_irq = 0;
        mret = 1; tick(); mret = 0;
        tick();
    endtask

    task automatic test_committed();
        int bad;
        mstatus_mie = 1; mie = 3'b001; timer_irq = 1;
        tick(); tick();
        timer_irq = 0; mstatus_mie = 0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (req_v !== 1'b1 || cause_v !== 32'h8000_0007) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL committed_hold: got %0d bad cycles, want 0", bad);
        end
        irq_ack = 1; tick(); irq_ack = 0;
        checks++;
        if ({req_v, inh_v, cause_v} !== {2'b01, 32'h8000_0007}) begin
            errors++;
            $display("FAIL committed_ack: got req=%b inh=%b cause=%h want 0 1 80000007",
                     req_v, inh_v, cause_v);
        end
        mret = 1; tick(); mret = 0;
        tick();
        checks++;
        if (req_v !== 1'b0) begin
            errors++; $display("FAIL committed_no_rereq: got %b want 0", req_v);
        end
    endtask

    task automatic test_direct_reset();
        mstatus_mie = 1; mie = 3'b010; mtvec_base = 32'h203; sw_irq = 1;
        tick(); tick();
        checks++;
        if ({req_d, cause_d, tgt_d, tgt_v} !== {1'b1, 32'h8000_0003, 32'h200, 32'h20C}) begin
            errors++;
            $display("FAIL direct_target: got req=%b cause=%h td=%h tv=%h want 1 80000003 200 20c",
                     req_d, cause_d, tgt_d, tgt_v);
        end
        irq_ack = 1; tick(); irq_ack = 0;
        rst_n = 0; tick();
        checks++;
        if ({req_d, inh_d, mip_d, cause_d, tgt_d, req_v, inh_v, mip_v, cause_v, tgt_v} !== 76'd0) begin
            errors++;
            $display("FAIL reset_in_active: got inh=%b mip=%b cause=%h tgt=%h want all 0",
                     inh_v, mip_v, cause_v, tgt_v);
        end
        rst_n = 1; sw_irq = 0;
        tick();
    endtask

    task automatic test_ext_latency();
        int lat;
        mstatus_mie = 1; mie = 3'b100; mtvec_base = 32'hFFFF_FFFE;
        tick();
        ext_irq = 1;
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            tick();
            if (req_v === 1'b1) lat = i;
        end
        checks++;
        if (lat != EXT_LAT) begin
            errors++; $display("FAIL ext_latency: got %0d want %0d", lat, EXT_LAT);
        end
        checks++;
        if ({tgt_v, tgt_d} !== {32'h0000_0028, 32'hFFFF_FFFC}) begin
            errors++;
            $display("FAIL target_wrap: got tv=%h td=%h want 00000028 fffffffc", tgt_v, tgt_d);
        end
        irq_ack = 1; ext_irq = 0; tick(); irq_ack = 0;
        tick(); tick(); tick();
        mret = 1; tick(); mret = 0;
        tick();
    endtask

    task automatic test_random();
        int bad;
        logic [31:0] bases [4];
        bases[0] = 32'h100; bases[1] = 32'hFFFF_FFFF;
        bases[2] = 32'h8000_0203; bases[3] = 32'h0;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(99) >= 2);
            timer_irq   = ($urandom_range(3) == 0);
            sw_irq      = ($urandom_range(3) == 0);
            ext_irq     = ($urandom_range(3) == 0);
            mstatus_mie = ($urandom_range(3) != 0);
            mie         = 3'($urandom);
            mtvec_base  = ($urandom_range(1) == 0) ? bases[$urandom_range(3)] : $urandom;
            irq_ack     = ($urandom_range(2) == 0);
            mret        = ($urandom_range(4) == 0);
            tick();
            checks++;
            if ({req_v, inh_v, mip_v, cause_v, tgt_v} !==
                {(m_phase == 1), (m_phase == 2), m_mip, m_cause, m_tv}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_v cyc %0d: got req=%b inh=%b mip=%b cause=%h tgt=%h want %b %b %b %h %h",
                             i, req_v, inh_v, mip_v, cause_v, tgt_v,
                             (m_phase == 1), (m_phase == 2), m_mip, m_cause, m_tv);
                bad++;
            end
            checks++;
            if ({req_d, inh_d, mip_d, cause_d, tgt_d} !==
                {(m_phase == 1), (m_phase == 2), m_mip, m_cause, m_td}) begin
                errors++;
                if (bad < 10)
                    $display("FAIL random_d cyc %0d: got req=%b inh=%b tgt=%h want %b %b %h",
                             i, req_d, inh_d, tgt_d, (m_phase == 1), (m_phase == 2), m_td);
                bad++;
            end
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        tick(); tick();
        test_reset();
        test_timer_vectored();
        test_priority();
        test_committed();
        test_direct_reset();
        test_ext_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 Parameter VECTORED, default 1, meaning: 1 = vectored trap target (base + 4*code), 0 = direct (base only).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 timer_irq  input  1  level machine-timer interrupt from the timer compare stage.
REQ-005 sw_irq  input  1  level machine-software interrupt.
REQ-006 ext_irq  input  1  level machine-external interrupt.
REQ-007 mstatus_mie  input  1  global interrupt enable.
REQ-008 mie  input  3  per-source enable: [2]=ext, [1]=sw, [0]=timer.
REQ-009 mtvec_base  input  32  trap base address; bits [1:0] ignored.
REQ-010 irq_ack  input  1  core accepts the presented request.
REQ-011 mret  input  1  core returns from the handler.
REQ-012 irq_req  output  1  interrupt request to core.
REQ-013 irq_cause  output  32  mcause value for the presented request.
REQ-014 irq_target  output  32  handler PC for the presented request.
REQ-015 mip  output  3  registered pending bits, same bit order as mie.
REQ-016 in_handler  output  1  high while a handler is active.

Function
REQ-017 The block SHALL register mip <= {ext,sw,timer} every cycle, so mip lags the sources by 1 cycle.
REQ-018 The FSM SHALL have exactly three states: IDLE, REQ, ACTIVE.
REQ-019 IDLE -> REQ on the edge where mstatus_mie=1 and (mip & mie) != 0; irq_req is high from the following cycle.
REQ-020 Source-to-irq_req latency SHALL be 2 cycles.
REQ-021 Priority SHALL be ext > sw > timer. Codes are 11, 3, 7 respectively, and irq_cause = {1'b1, 27'b0, code}.
REQ-022 irq_cause and irq_target SHALL be latched on IDLE->REQ and held stable through REQ and ACTIVE.
REQ-023 In REQ, irq_req SHALL stay high until irq_ack=1, even if the source deasserts or mstatus_mie/mie drop; the request is committed.
REQ-024 REQ -> ACTIVE on irq_ack=1; irq_req drops the next cycle. A back-to-back re-request is not allowed in the ack cycle.
REQ-025 ACTIVE: in_handler=1, irq_req=0, and no new request is evaluated; ACTIVE -> IDLE on mret=1.
REQ-026 mret in IDLE or REQ SHALL be ignored. irq_ack in IDLE or ACTIVE SHALL be ignored.
REQ-027 After ACTIVE->IDLE, a still-pending enabled source SHALL re-request per REQ-019 (level semantics, no edge latching).
REQ-028 irq_target SHALL be {mtvec_base[31:2],2'b00} + 4*code when VECTORED=1, else {mtvec_base[31:2],2'b00}; 32-bit addition, wrap-around discarded.

Reset
REQ-029 While rst_n=0 at an edge: state=IDLE, mip=0, irq_req=0, irq_cause=0, irq_target=0, in_handler=0, synchronizer flops (if present)=0.
REQ-030 Reset asserted mid-request or mid-handler SHALL abandon it; no request is presented in the first cycle after reset release.

Configuration
REQ-031 Macro IRQ_EXT_SYNC_EN: when defined, ext_irq SHALL pass through a 2-flop synchronizer before mip[2]; ext latency becomes 4 cycles, sw/timer unchanged.
REQ-032 Without IRQ_EXT_SYNC_EN, ext_irq SHALL be sampled directly per REQ-017.

Verification
REQ-033 mstatus_mie=1, mie=3'b001, mtvec_base=0x100, VECTORED=1, timer_irq rises at cycle 0 -> irq_req=1 at cycle 2, irq_cause=0x80000007, irq_target=0x11C.
REQ-034 All three sources rise in the same cycle, mie=3'b111 -> irq_cause=0x8000000B, irq_target=0x12C. After ack then mret with ext cleared -> next request has cause 0x80000003.
REQ-035 Timer request presented, timer_irq and mstatus_mie dropped before ack -> irq_req stays 1 with unchanged cause until ack, then in_handler=1.
REQ-036 mie=3'b000 or mstatus_mie=0 with sources high -> irq_req stays 0 for 20 cycles while mip=3'b111.
REQ-037 VECTORED=0, mtvec_base=0x203, sw request -> irq_target=0x200. rst_n=0 during ACTIVE -> all outputs 0 on the next cycle.
REQ-038 With IRQ_EXT_SYNC_EN defined, ext_irq rises at cycle 0 -> irq_req=1 at cycle 4.
